// File: rtl/dmem_hs_banked.sv
// dmem_hs_banked: RV32 data memory in four byte banks, valid/ready request port,
// fixed RD_LAT response. Optional macro DMEM_MISALIGN_ERR_EN: misaligned H/W -> rsp_err.
// Ports: clk, rst_n (async, active low);
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (request);
//   rsp_valid/rsp_rdata/rsp_err (one-cycle response, no backpressure).
module dmem_hs_banked #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0] CNT_INIT =
    (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  rsp_t pend, pend_nx;
  rsp_t rsp, rsp_nx;
  rsp_t acc;

  logic          accept;
  logic          ill_f3;
  logic          in_rng;
  logic          misal;
  logic          err_c;
  logic          is_h;
  logic          is_w;
  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic [1:0]    eoff;
  logic [3:0]    be;
  logic [3:0]    wr_en;
  logic [31:0]   wdat;
  logic [31:0]   rd_word;
  logic [31:0]   sh;
  logic [31:0]   ext;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // BASE_ADDR is span-aligned, so the offset's low bits equal addr[1:0].
  assign off    = req_addr - BASE_ADDR;
  assign in_rng = (req_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign widx   = off[AW+1:2];

  assign ill_f3 = !(req_funct3 inside
    {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

  assign is_h = (req_funct3[1:0] == 2'b01);
  assign is_w = (req_funct3[1:0] == 2'b10);

`ifdef DMEM_MISALIGN_ERR_EN
  assign misal = (is_h && req_addr[0]) ||
                 (is_w && (req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign err_c = ill_f3 || !in_rng || misal;

  // Lane enables and replicated store data; offset aligned down to size.
  always_comb begin
    be   = 4'b0000;
    wdat = req_wdata;
    eoff = req_addr[1:0];
    unique case (1'b1)
      is_w: begin
        be   = 4'b1111;
        eoff = 2'b00;
      end
      is_h: begin
        be   = 4'b0011 << {req_addr[1], 1'b0};
        eoff = {req_addr[1], 1'b0};
        wdat = {2{req_wdata[15:0]}};
      end
      default: begin
        be   = 4'b0001 << req_addr[1:0];
        wdat = {4{req_wdata[7:0]}};
      end
    endcase
  end

  assign wr_en = (accept && req_we && !err_c) ? be : 4'b0000;

  for (genvar l = 0; l < 4; l++) begin : g_bank
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en[l]) mem[widx] <= wdat[8*l +: 8];
    end

    assign rd_word[8*l +: 8] = mem[widx];
  end

  assign sh = rd_word >> {eoff, 3'b000};

  always_comb begin
    ext = 32'h0;
    case (req_funct3)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b010:  ext = sh;
      3'b100:  ext = {24'h0, sh[7:0]};
      3'b101:  ext = {16'h0, sh[15:0]};
      default: ext = 32'h0;
    endcase
  end

  assign acc.data = (req_we || err_c) ? 32'h0 : ext;
  assign acc.err  = err_c;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    rsp_nx   = rsp;
    unique case (state)
      IDLE: begin
        if (accept) begin
          pend_nx = acc;
          if (RD_LAT == 1) begin
            state_nx = RESP;
            rsp_nx   = acc;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_nx = RESP;
          rsp_nx   = pend;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      pend  <= '0;
      rsp   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      rsp   <= rsp_nx;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp.data;
  assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_hs_banked.sv
// tb_dmem_hs_banked: randomized + directed bench for dmem_hs_banked
// against a byte-array model of the memory with an expected-response queue.
module tb_dmem_hs_banked;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_hs_banked #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LAT     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] last_d = 32'h0;
  logic        last_e = 1'b0;
  logic [31:0] m_d;
  logic        m_e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: byte-addressed memory, access size from funct3.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int sz;
    longint ea;
    logic [31:0] w;
    d  = 32'h0;
    e  = 1'b0;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      e = 1'b1;
    else if (longint'(a) < longint'(BASE) ||
             longint'(a) - longint'(BASE) >= longint'(DEPTH) * 4)
      e = 1'b1;
    else if ((a % sz) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      e = 1'b1;
`endif
    end
    if (e) return;
    ea = longint'(a) - longint'(a % sz) - longint'(BASE);
    if (we) begin
      for (int i = 0; i < sz; i++) mem_m[ea+i] = wd[8*i +: 8];
    end else begin
      w = 32'h0;
      for (int i = 0; i < sz; i++)
        w = w | (32'(mem_m[ea+i]) << (8*i));
      if (!f3[2] && sz < 4 && w[8*sz-1])
        w = w | (32'hFFFF_FFFF << (8*sz));
      d = w;
    end
  endfunction

  // Acceptance monitor: applies each accepted request to the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_d = 32'h0;
      last_e = 1'b0;
    end else begin
      cyc++;
      if (req_valid && req_ready) begin
        model(req_we, req_funct3, req_addr, req_wdata, m_d, m_e);
        q.push_back('{cyc + LAT - 1, m_d, m_e});
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      if (q.size() > 0 && q[0].due < cyc) begin
        fail("rsp_missing");
        void'(q.pop_front());
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, q[0].d);
        chk("rsp_err", 32'(rsp_err), 32'(q[0].e));
        last_d = q[0].d;
        last_e = q[0].e;
        void'(q.pop_front());
      end else begin
        chk("hold_rdata", rsp_rdata, last_d);
        chk("hold_err", 32'(rsp_err), 32'(last_e));
      end
    end
  end

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic xact(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rd  = 32'h0;
    er  = 1'b0;
    lat = 0;
    n   = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      fail("rsp_timeout");
      return;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [2:0]  legal [5];
    logic [2:0]  f3;
    logic [31:0] a;
    int          n;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++)
      xact(1'b1, 3'b010, BASE + 32'(4*w), $urandom, rd, er, lat);

    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", 32'(er), 32'd0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("lw10", rd, 32'hDEADBEEF);
    chk("lw10_err", 32'(er), 32'd0);
    chk("lw10_lat", 32'(lat), 32'(LAT));

    xact(1'b1, 3'b000, 32'h11, 32'h0000_007F, rd, er, lat);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("sb_lw10", rd, 32'hDEAD7FEF);
    xact(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
    chk("lb13", rd, 32'hFFFFFFDE);
    xact(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    chk("lbu13", rd, 32'h000000DE);

    xact(1'b1, 3'b001, 32'h22, 32'h0000_8001, rd, er, lat);
    xact(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
    chk("lh22", rd, 32'hFFFF8001);
    xact(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
    chk("lhu22", rd, 32'h00008001);
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("lw20_hi", {16'h0, rd[31:16]}, 32'h00008001);

    xact(1'b0, 3'b010, BASE + 32'(DEPTH*4), 32'h0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_lat", 32'(lat), 32'(LAT));

    xact(1'b1, 3'b011, 32'h10, 32'h12345678, rd, er, lat);
    chk("f3_011_err", 32'(er), 32'd1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("f3_011_unchanged", rd, 32'hDEAD7FEF);

    xact(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("lw12_err", 32'(er), 32'd1);
    chk("lw12_rdata", rd, 32'h0);
`else
    chk("lw12_err", 32'(er), 32'd0);
    chk("lw12_rdata", rd, 32'hDEAD7FEF);
`endif

    // Store accepted, then reset while the access is still in WAIT.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'hCAFEF00D;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("reset_accept_timeout");
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    xact(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
    chk("lw30_after_rst", rd, 32'hCAFEF00D);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("lw10_after_rst", rd, 32'hDEAD7FEF);

    repeat (300) begin
      f3 = legal[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      a = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
      if ($urandom_range(0, 15) == 0)
        a = BASE + 32'(DEPTH*4) + 32'($urandom_range(0, 64));
      if ($urandom_range(0, 31) == 0) a = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact(1'($urandom_range(0, 1)), f3, a, $urandom, rd, er, lat);
      chk("rand_latency", 32'(lat), 32'(LAT));
    end

    repeat (6) @(negedge clk);
    if (q.size() != 0) fail("queue_not_empty");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
